apb_native_bridge: RTL
======================

# apb_native_bridge

Upstream master stage for the register-access tree: accepts one APB3 transfer at a time and drives it onto the reg_native_if request/ack handshake consumed by the first `slv_fsm` stage. It latches the APB address, write data and direction, then performs the native request and ack handshakes. It returns read data and a completion on `pready`. A programmable timeout aborts a hung access with `pslverr` and pulses `glb_srst` to flush the downstream chain.

## Interface
- `ADDR_WIDTH`, 64, address width on APB and the native side.
- `DATA_WIDTH`, 32, data width.
- `TIMEOUT`, 255, cycles allowed in REQ+ACK before abort; 0 disables the timeout.
- `TMR_WIDTH`, 8, timeout counter width; must satisfy TIMEOUT < 2^TMR_WIDTH.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable (access phase).
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  APB address.
- `pwdata`  in  DATA_WIDTH  APB write data.
- `pready`  out  1  transfer complete.
- `prdata`  out  DATA_WIDTH  read data, valid while `pready` is high.
- `pslverr`  out  1  error, valid while `pready` is high.
- `req_vld`  out  1  native request valid.
- `req_rdy`  in  1  native request ready.
- `ack_vld`  in  1  native ack valid.
- `ack_rdy`  out  1  native ack ready.
- `rd_en`  out  1  native read strobe.
- `wr_en`  out  1  native write strobe.
- `addr`  out  ADDR_WIDTH  native address.
- `wr_data`  out  DATA_WIDTH  native write data.
- `rd_data`  in  DATA_WIDTH  native read data, sampled on the ack handshake.
- `glb_srst`  out  1  one-cycle synchronous reset pulse to the downstream chain.

## Operation
The FSM has four states: IDLE, REQ, ACK and DONE.

- **IDLE**
  - When `psel`=1 and `penable`=0 (setup phase), latch `paddr`→`addr`, `pwdata`→`wr_data` and `pwrite`, clear the timeout counter, then go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `req_vld`=1. `wr_en`=latched `pwrite`; `rd_en`=~latched `pwrite`.
  - `req_vld`=1 and `req_rdy`=1 in the same cycle → ACK.
- **ACK**
  - `ack_rdy`=1.
  - `ack_vld`=1 → capture `rd_data` into `prdata` (writes capture it too; the value is don't-care), clear the error flag, then go to DONE.
- **DONE**
  - `pready`=1 for exactly one cycle; `pslverr`=error flag. Then go to IDLE.
- **Strobes outside REQ:** `req_vld`, `rd_en` and `wr_en` are 0 in every state except REQ.
- **Held outputs:** `addr` and `wr_data` hold their latched values until the next setup-phase capture.
- **APB inputs outside IDLE:** ignored in REQ, ACK and DONE. The APB master holds `psel`/`penable` per protocol, and the bridge does not check this.
- **Timeout counter** (TIMEOUT≠0):
  - Increments every cycle in REQ or ACK. It does not wrap.
  - When the counter = TIMEOUT−1 and no handshake completes that cycle: go to DONE with error flag=1 and `prdata`=0, and assert `glb_srst`=1 for that one cycle (registered, so it is high during the DONE cycle).
- **Handshake vs. timeout:** a handshake completing in the same cycle as the timeout wins; it is a normal completion with `pslverr`=0.
- **TIMEOUT=0:** no abort; `glb_srst` is constant 0.
- **Reset:** asynchronous reset → IDLE. All outputs are 0, including `prdata`, `addr`, `wr_data` and `glb_srst`, and the counter is 0. Reset mid-transfer drops the transfer; no `pready` is generated.

## Timing
- Setup phase seen at cycle 0 → REQ at cycle 1 (`req_vld` rises).
- `req_rdy`=1 at cycle 1 → ACK at cycle 2.
- `ack_vld`=1 at cycle 2 → `pready` at cycle 3.
- Minimum transfer: 4 cycles from setup to `pready`; APB sees 2 wait states.
- Each cycle of `req_rdy` or `ack_vld` stall adds one cycle.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Abort: `pready`/`pslverr`/`glb_srst` high exactly TIMEOUT+1 cycles after the setup phase.
- Back-to-back transfers: a new setup phase is accepted in the IDLE cycle immediately after DONE.

## Test plan
- **Write, zero stall:** setup with `paddr`=0x10, `pwdata`=0xA5A5_0001, `pwrite`=1; `req_rdy`=1, `ack_vld` at cycle 2 → `wr_en`=1 only at cycle 1, `addr`=0x10, `wr_data`=0xA5A5_0001; `pready`=1, `pslverr`=0 at cycle 3.
- **Read with stalls:** `req_rdy` held low 3 cycles, `ack_vld` delayed 2 cycles, `rd_data`=0xDEAD_BEEF → `rd_en` held through REQ; `pready` at cycle 8; `prdata`=0xDEAD_BEEF.
- **Timeout:** TIMEOUT=8, `req_rdy` never asserted → `pready`=1, `pslverr`=1, `prdata`=0, `glb_srst`=1 at cycle 9 only; FSM back in IDLE at cycle 10.
- **Timeout tie:** TIMEOUT=8, `ack_vld` in the exact expiry cycle → normal completion, `pslverr`=0, `glb_srst`=0.
- **Reset mid-ACK:** assert `rst_n`=0 during ACK → all outputs 0 immediately, no `pready`; the next transfer completes normally.
- **Back-to-back:** two transfers, second setup in the cycle after the first `pready` → both complete with correct data; no extra idle cycle.

Source files
------------

// File: rtl/apb_native_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_native_bridge
// Purpose  : Upstream master of the register-access tree. Accepts one APB3
//            transfer at a time, replays it on the native request/ack
//            handshake, and returns data/completion on pready. A programmable
//            timeout aborts a hung access with pslverr and pulses glb_srst to
//            flush the downstream chain.
// Ports    : clk, rst_n                       - clock, async active-low reset
//            psel/penable/pwrite/paddr/pwdata - APB request side
//            pready/prdata/pslverr            - APB completion side
//            req_vld/req_rdy/rd_en/wr_en/
//            addr/wr_data                     - native request channel
//            ack_vld/ack_rdy/rd_data          - native ack channel
//            glb_srst                         - downstream flush pulse
// Revision : 1.0 - initial release
// ============================================================================
module apb_native_bridge #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,  // 0 disables the abort path
  parameter int TMR_WIDTH  = 8     // must hold TIMEOUT-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  req_vld,
  input  logic                  req_rdy,
  input  logic                  ack_vld,
  output logic                  ack_rdy,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  glb_srst
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_q,    state_d;
  logic                    pwrite_q,   pwrite_d;
  logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q,  wr_data_d;
  logic [DATA_WIDTH-1:0]   prdata_q,   prdata_d;
  logic                    err_q,      err_d;
  logic                    glb_srst_q, glb_srst_d;

  logic w_setup;    // APB setup phase seen
  logic w_busy;     // transfer outstanding on the native side
  logic w_tmo_hit;  // last cycle allowed before abort

  assign w_setup = psel & ~penable;
  assign w_busy  = (state_q == ST_REQ) || (state_q == ST_ACK);

  // --------------------------------------------------------------------------
  // Timeout counter. It counts cycles spent in REQ+ACK and saturates instead
  // of wrapping, so once the expiry cycle has passed (e.g. the request
  // handshake won the tie) it can never fire again for this transfer.
  // --------------------------------------------------------------------------
  generate
    if (TIMEOUT != 0) begin : g_timeout
      localparam logic [TMR_WIDTH-1:0] c_tmo_last = TMR_WIDTH'(TIMEOUT - 1);

      logic [TMR_WIDTH-1:0] tmr_q, tmr_d;

      always_comb begin
        tmr_d = tmr_q;
        if (state_q == ST_IDLE) begin
          if (w_setup) begin
            tmr_d = '0;
          end
        end else if (w_busy && (tmr_q != {TMR_WIDTH{1'b1}})) begin
          tmr_d = tmr_q + TMR_WIDTH'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tmr_q <= '0;
        end else begin
          tmr_q <= tmr_d;
        end
      end

      assign w_tmo_hit = w_busy && (tmr_q == c_tmo_last);
    end else begin : g_no_timeout
      assign w_tmo_hit = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state / datapath. A completing handshake is checked before the
  // timeout so that a tie resolves as a normal completion.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pwrite_d   = pwrite_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    prdata_d   = prdata_q;
    err_d      = err_q;
    glb_srst_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (w_setup) begin
          pwrite_d  = pwrite;
          addr_d    = paddr;
          wr_data_d = pwdata;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        if (req_rdy) begin
          state_d = ST_ACK;
        end else if (w_tmo_hit) begin
          state_d    = ST_DONE;
          err_d      = 1'b1;
          prdata_d   = '0;
          glb_srst_d = 1'b1;
        end
      end

      ST_ACK: begin
        if (ack_vld) begin
          // Write acks also load prdata; the value is simply unused then.
          prdata_d = rd_data;
          err_d    = 1'b0;
          state_d  = ST_DONE;
        end else if (w_tmo_hit) begin
          state_d    = ST_DONE;
          err_d      = 1'b1;
          prdata_d   = '0;
          glb_srst_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pwrite_q   <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      prdata_q   <= '0;
      err_q      <= 1'b0;
      glb_srst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwrite_q   <= pwrite_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      prdata_q   <= prdata_d;
      err_q      <= err_d;
      glb_srst_q <= glb_srst_d;
    end
  end

  // Every output is a flop or a decode of the state register only.
  assign req_vld  = (state_q == ST_REQ);
  assign wr_en    = (state_q == ST_REQ) &  pwrite_q;
  assign rd_en    = (state_q == ST_REQ) & ~pwrite_q;
  assign ack_rdy  = (state_q == ST_ACK);
  assign pready   = (state_q == ST_DONE);
  assign pslverr  = (state_q == ST_DONE) & err_q;
  assign prdata   = prdata_q;
  assign addr     = addr_q;
  assign wr_data  = wr_data_q;
  assign glb_srst = glb_srst_q;

endmodule
`default_nettype wire
